// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer control: qualifies raw wr/rd against full/empty, keeps the extended
// pointers, occupancy count, threshold flags and saturating drop counters.
module fifo_ptr_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic              i_rd,
  output logic              o_fifo_we,
  output logic              o_fifo_rd,
  output logic [ADDR_W:0]   o_wptr,
  output logic [ADDR_W:0]   o_rptr,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W:0]   o_count,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [DROP_W-1:0] o_wr_drop_cnt,
  output logic [DROP_W-1:0] o_rd_drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AE_MARGIN);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [ADDR_W:0]   r_wptr, r_rptr, r_count;
  logic              r_almost_full, r_almost_empty;
  logic [DROP_W-1:0] r_wr_drop_cnt, r_rd_drop_cnt;

  logic              w_full, w_empty, w_wr_drop, w_rd_drop;
  logic [ADDR_W:0]   w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic              w_af_nxt, w_ae_nxt;
  logic [DROP_W-1:0] w_wr_drop_nxt, w_rd_drop_nxt;

  // Status comes from registered pointers only, so strobes never loop back through wr/rd.
  assign w_full    = (r_wptr[ADDR_W] ^ r_rptr[ADDR_W]) &&
                     (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_empty   = (r_wptr == r_rptr);
  assign o_fifo_we = i_wr & ~w_full  & ~i_clr;
  assign o_fifo_rd = i_rd & ~w_empty & ~i_clr;
  assign w_wr_drop = i_wr & w_full  & ~i_clr;
  assign w_rd_drop = i_rd & w_empty & ~i_clr;

  // Next-state: clear restores the reset image, otherwise advance pointers, count, flags, drops.
  always_comb begin
    w_wptr_nxt    = r_wptr;
    w_rptr_nxt    = r_rptr;
    w_count_nxt   = r_count;
    w_af_nxt      = r_almost_full;
    w_ae_nxt      = r_almost_empty;
    w_wr_drop_nxt = r_wr_drop_cnt;
    w_rd_drop_nxt = r_rd_drop_cnt;
    if (i_clr) begin
      w_wptr_nxt    = '0;
      w_rptr_nxt    = '0;
      w_count_nxt   = '0;
      w_af_nxt      = 1'b0;
      w_ae_nxt      = 1'b1;
      w_wr_drop_nxt = '0;
      w_rd_drop_nxt = '0;
    end else begin
      w_wptr_nxt  = r_wptr + {{ADDR_W{1'b0}}, o_fifo_we};
      w_rptr_nxt  = r_rptr + {{ADDR_W{1'b0}}, o_fifo_rd};
      w_count_nxt = r_count + {{ADDR_W{1'b0}}, o_fifo_we} - {{ADDR_W{1'b0}}, o_fifo_rd};
      w_af_nxt    = (w_count_nxt >= AF_TH);
      w_ae_nxt    = (w_count_nxt <= AE_TH);
      if (w_wr_drop && (r_wr_drop_cnt != DROP_MAX)) begin
        w_wr_drop_nxt = r_wr_drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
      end else begin
        w_wr_drop_nxt = r_wr_drop_cnt;
      end
      if (w_rd_drop && (r_rd_drop_cnt != DROP_MAX)) begin
        w_rd_drop_nxt = r_rd_drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
      end else begin
        w_rd_drop_nxt = r_rd_drop_cnt;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_wr_drop_cnt  <= '0;
      r_rd_drop_cnt  <= '0;
    end else begin
      r_wptr         <= w_wptr_nxt;
      r_rptr         <= w_rptr_nxt;
      r_count        <= w_count_nxt;
      r_almost_full  <= w_af_nxt;
      r_almost_empty <= w_ae_nxt;
      r_wr_drop_cnt  <= w_wr_drop_nxt;
      r_rd_drop_cnt  <= w_rd_drop_nxt;
    end
  end

  assign o_wptr         = r_wptr;
  assign o_rptr         = r_rptr;
  assign o_waddr        = r_wptr[ADDR_W-1:0];
  assign o_raddr        = r_rptr[ADDR_W-1:0];
  assign o_count        = r_count;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_wr_drop_cnt  = r_wr_drop_cnt;
  assign o_rd_drop_cnt  = r_rd_drop_cnt;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: a queue-based FIFO model predicts strobes and
// registered state; a negedge monitor pops expectations and compares.
module tb_fifo_ptr_ctrl;
  localparam int DEPTH = 16;
  localparam int DMAX  = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_clr = 1'b0, i_wr = 1'b0, i_rd = 1'b0;
  logic       o_fifo_we, o_fifo_rd, o_almost_full, o_almost_empty;
  logic [4:0] o_wptr, o_rptr, o_count;
  logic [3:0] o_waddr, o_raddr;
  logic [7:0] o_wr_drop_cnt, o_rd_drop_cnt;

  fifo_ptr_ctrl #(.ADDR_W(4), .AF_MARGIN(2), .AE_MARGIN(2), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_wr(i_wr), .i_rd(i_rd),
    .o_fifo_we(o_fifo_we), .o_fifo_rd(o_fifo_rd),
    .o_wptr(o_wptr), .o_rptr(o_rptr), .o_waddr(o_waddr), .o_raddr(o_raddr),
    .o_count(o_count), .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .o_wr_drop_cnt(o_wr_drop_cnt), .o_rd_drop_cnt(o_rd_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       rd;
    logic [4:0] wptr, rptr, count;
    logic       af, ae;
    logic [7:0] wdc, rdc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: contents queue plus total-transfer counters.
  int mq[$];
  int m_wtot = 0, m_rtot = 0, m_wd = 0, m_rd = 0;

  function automatic exp_t snap(bit we, bit re);
    exp_t e;
    e.we    = we;
    e.rd    = re;
    e.wptr  = 5'(m_wtot % 32);
    e.rptr  = 5'(m_rtot % 32);
    e.count = 5'(mq.size());
    e.af    = (mq.size() >= DEPTH - 2);
    e.ae    = (mq.size() <= 2);
    e.wdc   = 8'(m_wd);
    e.rdc   = 8'(m_rd);
    return e;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_wtot = 0; m_rtot = 0; m_wd = 0; m_rd = 0;
  endtask

  task automatic step(input bit w, input bit r, input bit c);
    bit we, re;
    @(posedge clk); #1;
    i_wr = w; i_rd = r; i_clr = c;
    we = w && !c && (mq.size() < DEPTH);
    re = r && !c && (mq.size() > 0);
    sb.push_back(snap(we, re));
    if (c) begin
      m_reset();
    end else begin
      if (w && !we) m_wd = (m_wd < DMAX) ? m_wd + 1 : DMAX;
      if (r && !re) m_rd = (m_rd < DMAX) ? m_rd + 1 : DMAX;
      if (re) begin
        void'(mq.pop_front());
        m_rtot = m_rtot + 1;
      end
      if (we) begin
        mq.push_back(int'($urandom));
        m_wtot = m_wtot + 1;
      end
    end
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    i_wr = 1'b0; i_rd = 1'b0; i_clr = 1'b0;
    m_reset();
    sb.push_back(snap(1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t cur;
  // Monitor: inputs and registered state are stable at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("fifo_we", 32'(o_fifo_we), 32'(cur.we));
      chk("fifo_rd", 32'(o_fifo_rd), 32'(cur.rd));
      chk("wptr", 32'(o_wptr), 32'(cur.wptr));
      chk("rptr", 32'(o_rptr), 32'(cur.rptr));
      chk("waddr", 32'(o_waddr), 32'(cur.wptr[3:0]));
      chk("raddr", 32'(o_raddr), 32'(cur.rptr[3:0]));
      chk("count", 32'(o_count), 32'(cur.count));
      chk("almost_full", 32'(o_almost_full), 32'(cur.af));
      chk("almost_empty", 32'(o_almost_empty), 32'(cur.ae));
      chk("wr_drop_cnt", 32'(o_wr_drop_cnt), 32'(cur.wdc));
      chk("rd_drop_cnt", 32'(o_rd_drop_cnt), 32'(cur.rdc));
    end
  end

  initial begin
    int wp, rp;
    m_reset();
    #1;
    sb.push_back(snap(1'b0, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);   // fill to full
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, 1'b0);   // writes dropped
    step(1'b1, 1'b1, 1'b0);                                // full: read only
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)  step(1'b0, 1'b1, 1'b0);   // reads dropped
    step(1'b1, 1'b1, 1'b0);                                // empty: write only
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);   // wrap at occupancy 5
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++)  step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);                                // clr beats wr
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 316; i++) step(1'b1, 1'b0, 1'b0);  // drop counter saturation
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    for (int ph = 0; ph < 4; ph++) begin
      wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      rp = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          async_reset();
        end else begin
          step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
               $urandom_range(0, 63) == 0);
        end
      end
    end
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Pointer-control stage of the FIFO memory. It accepts raw wr/rd requests and qualifies them against full/empty to produce the gated fifo_we/fifo_rd strobes for the RAM. It maintains the extended (ADDR_W+1)-bit write/read pointers that feed the downstream status block, and the RAM address ports. It also provides a registered occupancy count, almost-full/almost-empty flags and saturating counters of dropped requests.

Parameters:
ADDR_W, 4, RAM address width; depth = 2^ADDR_W = 16; pointers are ADDR_W+1 bits.
AF_MARGIN, 2, almost_full asserts when count >= DEPTH - AF_MARGIN.
AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN.
DROP_W, 8, width of the saturating drop counters.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
clr  input  1  synchronous clear of pointers, count, flags and drop counters.
wr  input  1  raw write request.
rd  input  1  raw read request.
fifo_we  output  1  gated write strobe to RAM (combinational).
fifo_rd  output  1  gated read strobe to RAM (combinational).
wptr  output  ADDR_W+1  write pointer, registered.
rptr  output  ADDR_W+1  read pointer, registered.
waddr  output  ADDR_W  RAM write address = wptr[ADDR_W-1:0].
raddr  output  ADDR_W  RAM read address = rptr[ADDR_W-1:0].
count  output  ADDR_W+1  occupancy 0..DEPTH, registered.
almost_full  output  1  registered threshold flag.
almost_empty  output  1  registered threshold flag.
wr_drop_cnt  output  DROP_W  writes rejected while full, saturating.
rd_drop_cnt  output  DROP_W  reads rejected while empty, saturating.

Behaviour:
- Reset (rst_n low, async): wptr=rptr=0, count=0, almost_full=0, almost_empty=1, drop counters=0.
- Internal full = (wptr[MSB]^rptr[MSB]) & (wptr[ADDR_W-1:0]==rptr[ADDR_W-1:0]). Internal empty = (wptr==rptr). Both are derived from registered pointers only; no combinational path from wr/rd.
- fifo_we = wr & ~full & ~clr. fifo_rd = rd & ~empty & ~clr. Zero latency (same cycle as the request).
- Rising edge with fifo_we: wptr <= wptr+1. Rising edge with fifo_rd: rptr <= rptr+1. Both pointers wrap modulo 2^(ADDR_W+1) (31 -> 0) with no special case.
- Simultaneous wr & rd:
  - normal: both pointers advance, count unchanged.
  - full: write blocked, read proceeds, count -1.
  - empty: read blocked, write proceeds, count +1. No write-through.
- count <= count + fifo_we - fifo_rd. Must always equal wptr - rptr, mod 2^(ADDR_W+1). Never exceeds DEPTH and never underflows.
- almost_full/almost_empty are computed from the next-state count and registered, so they track count in the same cycle.
- wr_drop_cnt increments on each cycle with wr & full & ~clr. rd_drop_cnt increments on each cycle with rd & empty & ~clr. Both hold at 2^DROP_W-1.
- clr (sync) has priority over wr/rd: next state equals the reset state and both strobes are 0 that cycle. Data in the RAM is not touched.
- Reset asserted mid-operation: all state returns immediately to reset values. Requests in flight are lost and not counted as drops.

Test Plan:
- Reset, then 16 wr pulses: fifo_we=1 on every pulse; wptr=16 (5'b10000), count=16, almost_full set once count=14, almost_empty clear once count=3; full seen downstream.
- Full, wr held 3 more cycles: fifo_we=0, wptr stays 16, wr_drop_cnt=3.
- Full, wr & rd together for 1 cycle: fifo_rd=1, fifo_we=0, rptr=1, count=15.
- Empty after reset, rd for 2 cycles: fifo_rd=0, rd_drop_cnt=2. Then wr & rd together: fifo_we=1, fifo_rd=0, count=1.
- Wrap: 40 write/read pairs with occupancy held at 5. wptr and rptr wrap 31->0; count stays 5; raddr follows waddr by 5 modulo 16.
- At count=9, assert clr together with wr: fifo_we=0; next cycle wptr=rptr=0, count=0, almost_empty=1, drop counters=0. Repeat with rst_n pulsed mid-burst: same values asynchronously.
